// File: rtl/lct_quality_decode_run3_pkg.sv
// Shared definitions for the Run3 LCT quality decoder: quality codes,
// decoded flag bundle and the counter read-handshake states.
package lct_quality_decode_run3_pkg;

    typedef logic [2:0] q_t;

    localparam q_t Q_ACC_COPAD_BEND = 3'd7;
    localparam q_t Q_ACC_COPAD      = 3'd6;
    localparam q_t Q_ACC_GEM_BEND   = 3'd5;
    localparam q_t Q_ACC_GEM        = 3'd4;
    localparam q_t Q_ALCT_CLCT      = 3'd3;
    localparam q_t Q_ALCT_COPAD     = 3'd2;
    localparam q_t Q_CLCT_COPAD     = 3'd1;
    localparam q_t Q_NONE           = 3'd0;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic acc_copad;
        logic acc_gem;
        logic gemcsc_bend;
        logic alct_clct;
        logic alct_copad;
        logic clct_copad;
        logic q_invalid;
    } dec_flags_t;

    // Invalid-pattern crossings decode to all zeros regardless of the quality.
    function automatic dec_flags_t decode_q(input logic vpf, input q_t q);
        dec_flags_t f;
        f = '0;
        if (vpf) begin
            case (q)
                Q_ACC_COPAD_BEND: begin f.acc_copad = 1'b1; f.gemcsc_bend = 1'b1; end
                Q_ACC_COPAD:      f.acc_copad = 1'b1;
                Q_ACC_GEM_BEND:   begin f.acc_gem = 1'b1; f.gemcsc_bend = 1'b1; end
                Q_ACC_GEM:        f.acc_gem = 1'b1;
                Q_ALCT_CLCT:      f.alct_clct = 1'b1;
                Q_ALCT_COPAD:     f.alct_copad = 1'b1;
                Q_CLCT_COPAD:     f.clct_copad = 1'b1;
                Q_NONE:           f.q_invalid = 1'b1;
                default:          f = '0;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/lct_quality_decode_run3_if.sv
// LCT input, decoded flags and counter read bus of the quality decoder.
interface lct_quality_decode_run3_if
    import lct_quality_decode_run3_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             lct_vpf;
    q_t               lct_q;
    logic             cnt_en;
    logic             cnt_clear;
    logic [2:0]       cnt_sel;
    logic             cnt_rd;
    logic             dec_vpf;
    logic             acc_copad;
    logic             acc_gem;
    logic             gemcsc_bend;
    logic             alct_clct;
    logic             alct_copad;
    logic             clct_copad;
    logic             q_invalid;
    logic [CNT_W-1:0] cnt_rdata;
    logic             cnt_ack;

    modport master (
        output lct_vpf, lct_q, cnt_en, cnt_clear, cnt_sel, cnt_rd,
        input  dec_vpf, acc_copad, acc_gem, gemcsc_bend, alct_clct,
               alct_copad, clct_copad, q_invalid, cnt_rdata, cnt_ack
    );

    modport slave (
        input  lct_vpf, lct_q, cnt_en, cnt_clear, cnt_sel, cnt_rd,
        output dec_vpf, acc_copad, acc_gem, gemcsc_bend, alct_clct,
               alct_copad, clct_copad, q_invalid, cnt_rdata, cnt_ack
    );
endinterface

// File: rtl/lct_quality_decode_run3_sat_counter.sv
// Saturating occupancy counter: clear has priority, holds at all-ones.
module lct_quality_decode_run3_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lct_quality_decode_run3.sv
// Run3 LCT quality decoder with per-quality saturating counters and a
// select/read/ack handshake for the register bank.
module lct_quality_decode_run3
    import lct_quality_decode_run3_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    lct_quality_decode_run3_if.slave  bus
);

    dec_flags_t       flags;
    logic             dec_vpf;
    logic [CNT_W-1:0] cnt [8];
    logic             count_event;
    rd_state_e        state;
    rd_state_e        state_next;
    logic             capture;
    logic             ack;
    logic [CNT_W-1:0] rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dec_vpf <= 1'b0;
            flags   <= '0;
        end else begin
            dec_vpf <= bus.lct_vpf;
            flags   <= decode_q(bus.lct_vpf, bus.lct_q);
        end
    end

    assign count_event = bus.lct_vpf && bus.cnt_en && !bus.cnt_clear;

    for (genvar i = 0; i < 8; i++) begin : g_cnt
        lct_quality_decode_run3_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (count_event && (bus.lct_q == q_t'(i))),
            .clr     (bus.cnt_clear),
            .value   (cnt[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ack        = 1'b0;
        case (state)
            RD_IDLE: begin
                if (bus.cnt_rd) begin
                    capture    = 1'b1;
                    state_next = RD_ACK;
                end
            end
            RD_ACK: begin
                ack        = 1'b1;
                state_next = RD_HOLD;
            end
            RD_HOLD: begin
                if (!bus.cnt_rd) state_next = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // Counters are registers, so this picks up the value before any
    // same-cycle increment or clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= cnt[bus.cnt_sel];
        end
    end

    assign bus.dec_vpf     = dec_vpf;
    assign bus.acc_copad   = flags.acc_copad;
    assign bus.acc_gem     = flags.acc_gem;
    assign bus.gemcsc_bend = flags.gemcsc_bend;
    assign bus.alct_clct   = flags.alct_clct;
    assign bus.alct_copad  = flags.alct_copad;
    assign bus.clct_copad  = flags.clct_copad;
    assign bus.q_invalid   = flags.q_invalid;
    assign bus.cnt_rdata   = rdata;
    assign bus.cnt_ack     = ack;

endmodule

// File: tb/tb_lct_quality_decode_run3.sv
// Self-checking bench for lct_quality_decode_run3: directed scenarios plus a
// randomized LCT stream compared against a behavioural counter model.
module tb_lct_quality_decode_run3;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    lct_quality_decode_run3_if #(.CNT_W(CNT_W)) bus ();

    lct_quality_decode_run3 #(.CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int model_cnt [8];

    // Expected {dec_vpf, acc_copad, acc_gem, gemcsc_bend, alct_clct, alct_copad, clct_copad, q_invalid}
    function automatic logic [7:0] exp_dec(input logic vpf, input int q);
        if (!vpf) return 8'h00;
        return {1'b1, (q >= 6), (q == 4 || q == 5), (q == 7 || q == 5),
                (q == 3), (q == 2), (q == 1), (q == 0)};
    endfunction

    function automatic logic [7:0] obs_dec();
        return {bus.dec_vpf, bus.acc_copad, bus.acc_gem, bus.gemcsc_bend,
                bus.alct_clct, bus.alct_copad, bus.clct_copad, bus.q_invalid};
    endfunction

    task automatic drive(input logic vpf, input int q, input logic en, input logic clr);
        bus.lct_vpf   = vpf;
        bus.lct_q     = 3'(q);
        bus.cnt_en    = en;
        bus.cnt_clear = clr;
    endtask

    // One clock: the model sees the same inputs the DUT samples at this edge.
    task automatic tick();
        @(posedge clock);
        if (reset_n) begin
            if (bus.cnt_clear) begin
                for (int i = 0; i < 8; i++) model_cnt[i] = 0;
            end else if (bus.lct_vpf && bus.cnt_en && model_cnt[int'(bus.lct_q)] < CNT_MAX) begin
                model_cnt[int'(bus.lct_q)]++;
            end
        end
        #1;
    endtask

    // Full read transaction; returns what was observed, the caller judges it.
    task automatic do_read(input int sel, output logic ack_first, output logic ack_after,
                           output logic [CNT_W-1:0] data);
        bus.cnt_sel = 3'(sel);
        bus.cnt_rd  = 1'b1;
        tick();
        ack_first = bus.cnt_ack;
        data      = bus.cnt_rdata;
        bus.cnt_rd = 1'b0;
        tick();
        ack_after = bus.cnt_ack;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 7, 1'b1, 1'b0);
        bus.cnt_sel = 3'd7;
        bus.cnt_rd  = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs_dec() !== 8'h00) begin
            errors++; $display("FAIL reset_decode: got %b expected %b", obs_dec(), 8'h00);
        end
        checks++;
        if (bus.cnt_ack !== 1'b0 || bus.cnt_rdata !== '0) begin
            errors++; $display("FAIL reset_read: got ack=%b data=%0d expected ack=0 data=0", bus.cnt_ack, bus.cnt_rdata);
        end
        bus.cnt_rd = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_decode_sweep();
        for (int q = 7; q >= 0; q--) begin
            drive(1'b1, q, 1'b1, 1'b0);
            tick();
            checks++;
            if (obs_dec() !== exp_dec(1'b1, q)) begin
                errors++; $display("FAIL sweep_q%0d: got %b expected %b", q, obs_dec(), exp_dec(1'b1, q));
            end
        end
    endtask

    task automatic test_vpf_low();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        int exp7;
        exp7 = model_cnt[7];
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7, 1'b1, 1'b0);
            tick();
            checks++;
            if (obs_dec() !== 8'h00) begin
                errors++; $display("FAIL vpf_low_decode_%0d: got %b expected %b", i, obs_dec(), 8'h00);
            end
        end
        do_read(7, a1, a2, d);
        checks++;
        if (a1 !== 1'b1 || d !== CNT_W'(exp7)) begin
            errors++; $display("FAIL vpf_low_count: got ack=%b data=%0d expected ack=1 data=%0d", a1, d, exp7);
        end
    endtask

    task automatic test_count_and_read();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        int acks;
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin drive(1'b1, 3, 1'b1, 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1'b1, 3, 1'b0, 1'b0); tick(); end
        drive(1'b0, 0, 1'b0, 1'b0);
        do_read(3, a1, a2, d);
        checks++;
        if (a1 !== 1'b1 || a2 !== 1'b0 || d !== CNT_W'(5)) begin
            errors++; $display("FAIL count_read3: got ack=%b,%b data=%0d expected ack=1,0 data=5", a1, a2, d);
        end
        bus.cnt_sel = 3'd3;
        bus.cnt_rd  = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.cnt_ack === 1'b1) acks++;
        end
        bus.cnt_rd = 1'b0;
        tick();
        if (bus.cnt_ack === 1'b1) acks++;
        tick();
        checks++;
        if (acks !== 1) begin
            errors++; $display("FAIL held_rd_acks: got %0d expected 1", acks);
        end
    endtask

    task automatic test_saturation();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        for (int i = 0; i < 20; i++) begin drive(1'b1, 6, 1'b1, 1'b0); tick(); end
        drive(1'b0, 0, 1'b0, 1'b0);
        do_read(6, a1, a2, d);
        checks++;
        if (d !== CNT_W'(CNT_MAX) || d !== CNT_W'(model_cnt[6])) begin
            errors++; $display("FAIL saturate_q6: got %0d expected %0d", d, CNT_MAX);
        end
        drive(1'b1, 6, 1'b1, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        do_read(6, a1, a2, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL clear_beats_inc: got %0d expected 0", d);
        end
    endtask

    task automatic test_read_collisions();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        for (int i = 0; i < 2; i++) begin drive(1'b1, 1, 1'b1, 1'b0); tick(); end
        bus.cnt_sel = 3'd1;
        bus.cnt_rd  = 1'b1;
        drive(1'b1, 1, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.cnt_ack !== 1'b1 || bus.cnt_rdata !== CNT_W'(2)) begin
            errors++; $display("FAIL read_vs_inc: got ack=%b data=%0d expected ack=1 data=2", bus.cnt_ack, bus.cnt_rdata);
        end
        bus.cnt_rd = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        tick(); tick();
        do_read(1, a1, a2, d);
        checks++;
        if (d !== CNT_W'(3)) begin
            errors++; $display("FAIL read_after_inc: got %0d expected 3", d);
        end
        bus.cnt_sel = 3'd1;
        bus.cnt_rd  = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        checks++;
        if (bus.cnt_rdata !== CNT_W'(3)) begin
            errors++; $display("FAIL read_vs_clear: got %0d expected 3", bus.cnt_rdata);
        end
        bus.cnt_rd = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        tick(); tick();
        do_read(1, a1, a2, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL read_after_clear: got %0d expected 0", d);
        end
    endtask

    task automatic test_random();
        logic vpf, en, clr, a1, a2;
        logic [CNT_W-1:0] d;
        int q;
        for (int n = 0; n < 400; n++) begin
            vpf = ($urandom_range(0, 3) != 0);
            q   = int'($urandom_range(0, 7));
            en  = ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 49) == 0);
            drive(vpf, q, en, clr);
            tick();
            checks++;
            if (obs_dec() !== exp_dec(vpf, q)) begin
                errors++; $display("FAIL random_decode_%0d: got %b expected %b", n, obs_dec(), exp_dec(vpf, q));
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        for (int s = 0; s < 8; s++) begin
            do_read(s, a1, a2, d);
            checks++;
            if (a1 !== 1'b1 || a2 !== 1'b0 || d !== CNT_W'(model_cnt[s])) begin
                errors++; $display("FAIL random_cnt%0d: got ack=%b,%b data=%0d expected ack=1,0 data=%0d",
                                   s, a1, a2, d, model_cnt[s]);
            end
        end
    endtask

    task automatic test_reset_midread();
        logic a1, a2;
        logic [CNT_W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, int'($urandom_range(1, 7)), 1'b1, 1'b0);
            tick();
        end
        bus.cnt_sel = 3'd2;
        bus.cnt_rd  = 1'b1;
        drive(1'b1, 2, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.cnt_ack !== 1'b1) begin
            errors++; $display("FAIL midread_in_ack: got ack=%b expected 1", bus.cnt_ack);
        end
        #1 reset_n = 1'b0;
        for (int i = 0; i < 8; i++) model_cnt[i] = 0;
        #1;
        checks++;
        if (obs_dec() !== 8'h00 || bus.cnt_ack !== 1'b0 || bus.cnt_rdata !== '0) begin
            errors++; $display("FAIL midread_reset_outputs: got dec=%b ack=%b data=%0d expected dec=0 ack=0 data=0",
                               obs_dec(), bus.cnt_ack, bus.cnt_rdata);
        end
        tick(); tick();
        bus.cnt_rd = 1'b0;
        drive(1'b1, 5, 1'b1, 1'b0);
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (obs_dec() !== exp_dec(1'b1, 5)) begin
            errors++; $display("FAIL resume_decode: got %b expected %b", obs_dec(), exp_dec(1'b1, 5));
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        do_read(5, a1, a2, d);
        checks++;
        if (a1 !== 1'b1 || d !== CNT_W'(1)) begin
            errors++; $display("FAIL resume_cnt5: got ack=%b data=%0d expected ack=1 data=1", a1, d);
        end
        do_read(2, a1, a2, d);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL reset_cleared_cnt2: got %0d expected 0", d);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_cnt[i] = 0;
        drive(1'b0, 0, 1'b0, 1'b0);
        bus.cnt_sel = 3'd0;
        bus.cnt_rd  = 1'b0;
        test_reset();
        test_decode_sweep();
        test_vpf_low();
        test_count_and_read();
        test_saturation();
        test_read_collisions();
        test_random();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
